// File: rtl/serial_adder_if.sv
// serial_adder_if: valid/ready operand and result channels of the bit-serial adder
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one full-adder cell and a carry flop
module serial_adder #(parameter int WIDTH = 8) (
    input logic           clk,
    input logic           rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_q;
    logic             carry, cout_q, s, c_nx, last;
    logic [CW-1:0]    cnt;
    assign s    = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_nx = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign last = cnt == CW'(WIDTH - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.in_valid ? ADD : IDLE;
            ADD:     state_nx = last ? DONE : ADD;
            DONE:    state_nx = bus.out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // sum_q/cout_q hold the presented result, so sum stays stable while the next operation shifts
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            cnt    <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
        end else if (state == ADD) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= {s, sum_sr[WIDTH-1:1]};
            carry  <= c_nx;
            cnt    <= cnt + 1'b1;
            if (last) begin
                sum_q  <= {s, sum_sr[WIDTH-1:1]};
                cout_q <= c_nx;
            end
        end
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and tied-handshake checks of the bit-serial adder
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    serial_adder_if #(8) bus();
    serial_adder #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = c;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) begin
                k = i;
                break;
            end
        end
        chk({tag, "_lat"}, k, 8);
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] ref_v;
        realtime    t_prev, t_now;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        #12 rst_n = 1'b1;

        start(8'h5A, 8'h3C, 1'b0);
        chk("t1_busy_in_ready", bus.in_ready, 0);
        wait_done("t1");
        chk("t1_sum", bus.sum, 8'h96);
        chk("t1_cout", bus.cout, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t3_hold_valid", bus.out_valid, 1);
            chk("t3_hold_sum", bus.sum, 8'h96);
            chk("t3_hold_cout", bus.cout, 0);
            chk("t3_hold_in_ready", bus.in_ready, 0);
        end
        release_result();
        chk("t3_idle_in_ready", bus.in_ready, 1);
        chk("t3_idle_out_valid", bus.out_valid, 0);
        chk("t3_sum_kept", bus.sum, 8'h96);

        start(8'hFF, 8'h01, 1'b0);
        wait_done("t2a");
        chk("t2a_sum", bus.sum, 8'h00);
        chk("t2a_cout", bus.cout, 1);
        release_result();
        start(8'hFF, 8'hFF, 1'b1);
        wait_done("t2b");
        chk("t2b_sum", bus.sum, 8'hFF);
        chk("t2b_cout", bus.cout, 1);
        release_result();

        start(8'h5A, 8'h3C, 1'b0);
        bus.in_valid = 1'b1;
        bus.a = 8'h11;
        bus.b = 8'h22;
        wait_done("t4");
        chk("t4_sum", bus.sum, 8'h96);
        chk("t4_cout", bus.cout, 0);
        release_result();
        @(posedge clk);
        @(negedge clk);
        chk("t4_not_accepted", bus.in_ready, 1);

        start(8'hFF, 8'h01, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_in_ready", bus.in_ready, 1);
        chk("t5_out_valid", bus.out_valid, 0);
        chk("t5_sum", bus.sum, 0);
        chk("t5_cout", bus.cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        start(8'h01, 8'h01, 1'b0);
        wait_done("t5");
        chk("t5_sum_after", bus.sum, 8'h02);
        chk("t5_cout_after", bus.cout, 0);
        release_result();

        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        t_prev = 0;
        for (int n = 0; n < 200; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            ref_v = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
            bus.a = ra;
            bus.b = rb;
            bus.cin = rc;
            t_now = $realtime;
            chk("t6_in_ready", bus.in_ready, 1);
            if (n > 0) chk("t6_interval", 32'(int'(t_now - t_prev)), 100);
            t_prev = t_now;
            @(posedge clk);
            wait_done("t6");
            chk("t6_sum", bus.sum, ref_v[7:0]);
            chk("t6_cout", bus.cout, ref_v[8]);
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
